sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-master, one-slave arbiter for the SRAM-like bus (req / addr_ok / data_ok handshake) between the instruction cache miss port, the data-side port and the single memory port toward the bus bridge. It allows one outstanding transaction at a time. The data side has fixed priority, with a bounded-starvation guard for instruction fetches. Read data is broadcast to both masters, and each handshake strobe is routed only to the owning master.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req waits; legal range 1..15.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-low.
- inst_req, inst_wr  in  1 each  instruction-side request and write flag.
- inst_size  in  2  instruction-side transfer size.
- inst_addr, inst_wdata  in  32 each  instruction-side address and write data.
- inst_rdata  out  32  equals mem_rdata.
- inst_addr_ok, inst_data_ok  out  1 each  instruction-side handshake strobes.
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data-side request fields.
- data_rdata  out  32  equals mem_rdata.
- data_addr_ok, data_data_ok  out  1 each  data-side handshake strobes.
- mem_req, mem_wr  out  1 each  memory-side request and write flag.
- mem_size  out  2  memory-side transfer size.
- mem_addr, mem_wdata  out  32 each  memory-side address and write data.
- mem_rdata  in  32  memory-side read data.
- mem_addr_ok, mem_data_ok  in  1 each  memory-side handshake strobes.

## Operation
- States:
  - IDLE: no transaction.
  - ADDR: grant locked, waiting for mem_addr_ok.
  - DATA: address accepted, waiting for mem_data_ok.
- Owner register `own` (0 = inst, 1 = data). Starvation counter `sc` is 4 bits.
- Grant selection in IDLE (combinational):
  - If only one req is high, that master wins.
  - If both are high: inst wins when sc == STARVE_LIMIT, otherwise data wins.
- Request mux:
  - IDLE: mem_req = inst_req | data_req.
  - ADDR: mem_req = the locked owner's req.
  - DATA: mem_req = 0.
  - mem_wr/size/addr/wdata come from the selected owner, or from the locked owner in ADDR. In DATA they are don't-care.
- addr_ok routing: in IDLE or ADDR, the owner's addr_ok = mem_addr_ok & mem_req. The other master's addr_ok = 0.
- data_ok routing: only in DATA, the owner's data_ok = mem_data_ok. In IDLE and ADDR, mem_data_ok is ignored and both data_ok outputs are 0.
- Transitions:
  - IDLE with no req: stay in IDLE.
  - IDLE with mem_req & mem_addr_ok: go to DATA and latch own.
  - IDLE with mem_req & !mem_addr_ok: go to ADDR and latch own.
  - ADDR with owner req & mem_addr_ok: go to DATA.
  - ADDR with owner req dropped: go to IDLE. The request is withdrawn, no transaction occurs, and sc is unchanged.
  - DATA with mem_data_ok: go to IDLE. A new grant is possible the next cycle only.
- Starvation counter, updated on each address acceptance (mem_req & mem_addr_ok):
  - Data accepted while inst_req = 1: sc = sc + 1, saturating at STARVE_LIMIT.
  - Inst accepted: sc = 0.
  - Any cycle in IDLE with inst_req = 0: sc = 0.
- Reset:
  - Forces state = IDLE, own = 0, sc = 0.
  - While rst = 0, mem_req and all four ok outputs are 0.
  - Reset mid-transaction abandons the transaction; a later mem_data_ok is ignored.

## Timing
- addr_ok and data_ok propagate combinationally from the memory side to the owner in the same cycle; there are no extra stages.
- The earliest transaction takes 2 cycles: address accepted in cycle N, data_ok in cycle N+1.
- Back-to-back throughput is one transaction per 2 cycles minimum, because the DATA-exit cycle never issues.
- Grant is stable from the first mem_req cycle until mem_addr_ok; a higher-priority arrival during ADDR does not preempt.
- mem_rdata is valid to the owner only in its data_ok cycle.

## Test plan
- **Single fetch:** inst_req = 1, inst_addr = 0xBFC00000, mem_addr_ok = 1 immediately, mem_data_ok one cycle later with mem_rdata = 0x3C1D0001.
  - Required: mem_addr = 0xBFC00000, inst_addr_ok in cycle 0, inst_data_ok and inst_rdata = 0x3C1D0001 in cycle 1, data_* strobes 0.
- **Conflict:** both reqs high in the same cycle (data_addr = 0x80001000, inst_addr = 0x80000000).
  - Required: data granted first; inst granted in the IDLE cycle after data_data_ok; mem_addr shows 0x80000000 only then.
- **Starvation:** inst_req held high, data_req held high, STARVE_LIMIT = 4.
  - Required: exactly 4 data transactions, then 1 inst transaction, then data resumes with sc = 0.
- **Locked grant:** inst in ADDR with mem_addr_ok held low for 3 cycles while data_req rises.
  - Required: mem_addr stays the inst address and data_addr_ok stays 0.
  - Then inst_req drops: state returns to IDLE, and data is granted the following cycle.
- **Spurious strobe:** mem_data_ok = 1 in IDLE.
  - Required: inst_data_ok = data_data_ok = 0.
- **Reset:** rst = 0 in DATA, then mem_data_ok = 1 after rst returns to 1.
  - Required: no data_ok pulses; mem_req = 0 during reset; the next request is granted normally.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Two-master / one-slave arbiter for an SRAM-like req / addr_ok / data_ok bus.
// One transaction is outstanding at a time. The data side has fixed priority,
// but after STARVE_LIMIT consecutive data grants with an instruction fetch
// waiting, the instruction side is granted once.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   inst_req/wr/size/addr/wdata   instruction-side request fields (in)
//   inst_rdata                    broadcast read data (out)
//   inst_addr_ok, inst_data_ok    instruction-side handshake strobes (out)
//   data_req/wr/size/addr/wdata   data-side request fields (in)
//   data_rdata                    broadcast read data (out)
//   data_addr_ok, data_data_ok    data-side handshake strobes (out)
//   mem_req/wr/size/addr/wdata    memory-side request fields (out)
//   mem_rdata                     memory-side read data (in)
//   mem_addr_ok, mem_data_ok      memory-side handshake strobes (in)
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic       own, own_nxt;    // 0 = inst, 1 = data
  logic [3:0] sc, sc_nxt;
  logic       sel;             // grant choice while IDLE
  logic       cur;             // master currently driving the memory side
  logic       cur_req;
  logic       accept;
  logic       dok;

  // Grant selection and request mux
  always_comb begin
    sel = data_req;
    if (inst_req && data_req) sel = (sc != LIMIT);
    cur     = (state == IDLE) ? sel : own;
    cur_req = cur ? data_req : inst_req;

    mem_req = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    mem_req = inst_req | data_req;
        ADDR:    mem_req = cur_req;
        default: mem_req = 1'b0;
      endcase
    end

    mem_wr    = cur ? data_wr    : inst_wr;
    mem_size  = cur ? data_size  : inst_size;
    mem_addr  = cur ? data_addr  : inst_addr;
    mem_wdata = cur ? data_wdata : inst_wdata;

    // mem_req is already 0 in DATA and in reset, so accept needs no state term
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & ~cur;
    data_addr_ok = accept &  cur;

    // data_ok only counts in DATA; strobes elsewhere are spurious
    dok          = rst & (state == DATA) & mem_data_ok;
    inst_data_ok = dok & ~own;
    data_data_ok = dok &  own;
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Next-state, ownership and starvation counter
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    sc_nxt    = sc;

    case (state)
      IDLE: begin
        if (mem_req) begin
          own_nxt   = sel;
          state_nxt = mem_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        // Owner withdrew its request: abandon without a transaction
        if (!cur_req)         state_nxt = IDLE;
        else if (mem_addr_ok) state_nxt = DATA;
      end
      DATA: begin
        if (mem_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == IDLE && !inst_req) sc_nxt = 4'd0;
    if (accept) begin
      if (!cur)                        sc_nxt = 4'd0;
      else if (inst_req && sc < LIMIT) sc_nxt = sc + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      own   <= 1'b0;
      sc    <= 4'd0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      sc    <= sc_nxt;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed scenarios followed by a randomized
// run compared cycle by cycle against a transaction-level reference model.
module tb_sram_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int checks = 0;
  int errors = 0;

  sram_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled 1 time unit later, well before the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++;
      if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) begin
        errors++;
        $display("FAIL reset_oks: got %b want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
      end
    end
    clear_inputs();
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_single_fetch();
    inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'hBFC00000) begin errors++; $display("FAIL fetch_mem_addr: got %h want bfc00000", mem_addr); end
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL fetch_inst_addr_ok: got %b want 1", inst_addr_ok); end
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL fetch_data_addr_ok: got %b want 0", data_addr_ok); end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C1D0001;
    #1;
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL fetch_inst_data_ok: got %b want 1", inst_data_ok); end
    checks++; if (inst_rdata !== 32'h3C1D0001) begin errors++; $display("FAIL fetch_inst_rdata: got %h want 3c1d0001", inst_rdata); end
    checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_data_data_ok: got %b want 0", data_data_ok); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_no_issue_in_data: got %b want 0", mem_req); end
    tick();
    clear_inputs();
    #1;
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_data_ok_once: got %b want 0", inst_data_ok); end
    tick();
  endtask

  task automatic test_conflict();
    inst_req = 1; inst_addr = 32'h80000000;
    data_req = 1; data_addr = 32'h80001000;
    mem_addr_ok = 1;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL conflict_data_first: got %b want 1", data_addr_ok); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL conflict_inst_waits: got %b want 0", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h80001000) begin errors++; $display("FAIL conflict_addr0: got %h want 80001000", mem_addr); end
    tick();
    data_req = 0; mem_data_ok = 1;
    #1;
    checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL conflict_data_data_ok: got %b want 1", data_data_ok); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL conflict_inst_not_in_data: got %b want 0", inst_addr_ok); end
    tick();
    mem_data_ok = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL conflict_inst_granted: got %b want 1", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h80000000) begin errors++; $display("FAIL conflict_addr1: got %h want 80000000", mem_addr); end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL conflict_inst_data_ok: got %b want 1", inst_data_ok); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation();
    string seq;
    string want;
    int    n;
    seq = ""; n = 0;
    want = "DDDDIDDDDI";
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (inst_addr_ok && data_addr_ok) seq = {seq, "X"};
      else if (inst_addr_ok) seq = {seq, "I"};
      else if (data_addr_ok) seq = {seq, "D"};
      if (inst_addr_ok || data_addr_ok) n++;
      tick();
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL starve_count: got %0d want 10", n); end
    checks++; if (seq != want) begin errors++; $display("FAIL starve_order: got %s want %s", seq, want); end
    clear_inputs();
    tick();
  endtask

  task automatic test_locked_grant();
    inst_req = 1; inst_addr = 32'h1FC00040; mem_addr_ok = 0;
    #1;
    checks++; if (mem_addr !== 32'h1FC00040) begin errors++; $display("FAIL lock_addr_c0: got %h want 1fc00040", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      data_req = 1; data_addr = 32'h00002000;
      #1;
      checks++; if (mem_addr !== 32'h1FC00040) begin errors++; $display("FAIL lock_addr_held: got %h want 1fc00040", mem_addr); end
      checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_data_addr_ok: got %b want 0", data_addr_ok); end
    end
    tick();
    inst_req = 0; mem_addr_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lock_withdraw_req: got %b want 0", mem_req); end
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_withdraw_no_grant: got %b want 0", data_addr_ok); end
    tick();
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL lock_data_next: got %b want 1", data_addr_ok); end
    checks++; if (mem_addr !== 32'h00002000) begin errors++; $display("FAIL lock_data_addr: got %h want 00002000", mem_addr); end
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL lock_data_data_ok: got %b want 1", data_data_ok); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious();
    mem_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({inst_data_ok, data_data_ok} !== 2'b00) begin
        errors++; $display("FAIL spurious_idle: got %b want 00", {inst_data_ok, data_data_ok});
      end
      tick();
    end
    // Strobe while a request sits in ADDR is also ignored
    inst_req = 1; mem_addr_ok = 0;
    #1;
    tick();
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL spurious_addr: got %b want 00", {inst_data_ok, data_data_ok});
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    data_req = 1; data_addr = 32'h00003000; mem_addr_ok = 1;
    tick();
    data_req = 1; mem_addr_ok = 0; rst = 0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
    tick();
    rst = 1; data_req = 0; mem_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL rstmid_stale_data_ok: got %b want 00", {inst_data_ok, data_data_ok});
    end
    tick();
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'h00000400; mem_addr_ok = 1;
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL rstmid_regrant: got %b want 1", inst_addr_ok); end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL rstmid_data_ok: got %b want 1", inst_data_ok); end
    tick();
    clear_inputs();
    tick();
  endtask

  // Reference model: tracks whether a transaction is waiting for its data,
  // whether a master has its request pinned waiting for address acceptance,
  // and how many data grants in a row have gone by with a fetch waiting.
  task automatic test_random();
    bit m_waiting, m_locked, m_who;
    int m_streak;
    bit who, e_req, e_ia, e_da, e_id, e_dd;
    m_waiting = 0; m_locked = 0; m_who = 0; m_streak = 0;
    rst = 0;
    tick();
    rst = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst         = ($urandom_range(0, 59) != 0);
      inst_req    = ($urandom_range(0, 9) < 6);
      data_req    = ($urandom_range(0, 9) < 6);
      inst_wr     = $urandom_range(0, 1);
      data_wr     = $urandom_range(0, 1);
      inst_size   = 2'($urandom_range(0, 3));
      data_size   = 2'($urandom_range(0, 3));
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_rdata   = $urandom;
      mem_addr_ok = $urandom_range(0, 1);
      mem_data_ok = $urandom_range(0, 1);
      #1;
      who = 0; e_req = 0; e_ia = 0; e_da = 0; e_id = 0; e_dd = 0;
      if (rst) begin
        if (m_waiting) begin
          if (mem_data_ok) begin
            if (m_who) e_dd = 1; else e_id = 1;
          end
        end else begin
          if (m_locked) who = m_who;
          else if (inst_req && data_req) who = (m_streak == LIMIT) ? 1'b0 : 1'b1;
          else who = data_req;
          e_req = who ? data_req : inst_req;
          if (e_req && mem_addr_ok) begin
            if (who) e_da = 1; else e_ia = 1;
          end
        end
      end
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_mem_req c%0d: got %b want %b", cyc, mem_req, e_req); end
      checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {e_ia, e_da, e_id, e_dd}) begin
        errors++;
        $display("FAIL rnd_oks c%0d: got %b want %b", cyc,
                 {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, {e_ia, e_da, e_id, e_dd});
      end
      checks++;
      if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
        errors++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h", cyc, inst_rdata, data_rdata, mem_rdata);
      end
      if (e_req) begin
        checks++;
        if ({mem_wr, mem_size, mem_addr, mem_wdata} !==
            (who ? {data_wr, data_size, data_addr, data_wdata} : {inst_wr, inst_size, inst_addr, inst_wdata})) begin
          errors++;
          $display("FAIL rnd_fields c%0d: got addr %h want %h (owner %0d)", cyc, mem_addr,
                   who ? data_addr : inst_addr, who);
        end
      end
      // Advance the model to the state that holds after the coming edge
      if (!rst) begin
        m_waiting = 0; m_locked = 0; m_who = 0; m_streak = 0;
      end else if (m_waiting) begin
        if (mem_data_ok) m_waiting = 0;
      end else begin
        if (!m_locked && !inst_req) m_streak = 0;
        if (e_req && mem_addr_ok) begin
          m_waiting = 1; m_locked = 0; m_who = who;
          if (!who) m_streak = 0;
          else if (inst_req && m_streak < LIMIT) m_streak++;
        end else if (e_req) begin
          m_locked = 1; m_who = who;
        end else begin
          m_locked = 0;
        end
      end
      tick();
    end
    clear_inputs();
    rst = 1;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_starvation();
    test_locked_grant();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
